// File: rtl/btb_fetch_pc_pkg.sv
// Shared definitions for the fetch-stage next-PC unit: BTB geometry,
// the entry layout and small helpers that split a PC into set index and tag.
package btb_fetch_pc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Index covers pc[SET_BITS+1:2]; the tag is everything above it.
    localparam int SET_BITS = 5;
    localparam int SETS     = 1 << SET_BITS;
    localparam int TAG_BITS = 30 - SET_BITS;

    typedef logic [SET_BITS-1:0] set_idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    typedef struct packed {
        logic        valid;
        tag_t        tag;
        logic [31:0] target;
        logic        is_jump;
    } btb_entry_t;

    function automatic set_idx_t pc_set(input logic [31:0] pc);
        return pc[SET_BITS+1:2];
    endfunction

    function automatic tag_t pc_tag(input logic [31:0] pc);
        return pc[31:SET_BITS+2];
    endfunction

endpackage

// File: rtl/btb_fetch_pc_if.sv
// Bundle of the fetch control, EX training and prediction signals of btb_fetch_pc.
// The master side (hazard unit / EX / predictor) drives controls and consumes the PC.
interface btb_fetch_pc_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        bp_predict;
    logic        upd_we;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jump;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        btb_hit;

    modport master (
        output stall, redirect, redirect_pc, bp_predict,
        output upd_we, upd_pc, upd_target, upd_taken, upd_is_jump,
        input  pc, pred_taken, pred_target, btb_hit
    );

    modport slave (
        input  stall, redirect, redirect_pc, bp_predict,
        input  upd_we, upd_pc, upd_target, upd_taken, upd_is_jump,
        output pc, pred_taken, pred_target, btb_hit
    );

endinterface

// File: rtl/btb_way_array.sv
// One way of the BTB: per-set valid bit, tag, target and jump flag.
// Two combinational read ports (fetch lookup, training probe) and one
// synchronous write port. Reads always return pre-write contents.
module btb_way_array
    import btb_fetch_pc_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  set_idx_t   i_lk_set,
    output btb_entry_t o_lk_entry,
    input  set_idx_t   i_pb_set,
    output btb_entry_t o_pb_entry,
    input  logic       i_we,
    input  set_idx_t   i_wr_set,
    input  btb_entry_t i_wr_entry
);

    logic [SETS-1:0] r_valid;
    tag_t            r_tag    [SETS];
    logic [31:0]     r_target [SETS];
    logic [SETS-1:0] r_jump;

    // Valid bits: cleared by reset, set on a write.
    // NOTE: state is assigned with <= so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_set] <= i_wr_entry.valid;
        end
    end

    // Payload arrays: written alongside the valid bit.
    // NOTE: payload storage has no reset; a cleared valid bit makes its contents irrelevant and keeps it RAM-friendly.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_set]    <= i_wr_entry.tag;
            r_target[i_wr_set] <= i_wr_entry.target;
            r_jump[i_wr_set]   <= i_wr_entry.is_jump;
        end
    end

    assign o_lk_entry.valid   = r_valid[i_lk_set];
    assign o_lk_entry.tag     = r_tag[i_lk_set];
    assign o_lk_entry.target  = r_target[i_lk_set];
    assign o_lk_entry.is_jump = r_jump[i_lk_set];

    assign o_pb_entry.valid   = r_valid[i_pb_set];
    assign o_pb_entry.tag     = r_tag[i_pb_set];
    assign o_pb_entry.target  = r_target[i_pb_set];
    assign o_pb_entry.is_jump = r_jump[i_pb_set];

endmodule

// File: rtl/btb_fetch_pc.sv
// Fetch-stage next-PC unit: owns the IF program counter and a 2-way
// set-associative BTB. Lookup is combinational on the current PC; EX
// resolution trains the BTB and redirects fetch on a mispredict.
module btb_fetch_pc
    import btb_fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic           clk,
    input logic           rstn,
    btb_fetch_pc_if.slave bus
);

    logic [31:0]     r_pc;
    logic [SETS-1:0] r_lru;          // per set: way to evict next

    set_idx_t        w_lk_set;
    tag_t            w_lk_tag;
    btb_entry_t      w_lk_entry [2];
    logic            w_hit0;
    logic            w_hit1;
    logic            w_btb_hit;
    logic            w_hit_jump;
    logic [31:0]     w_pc_plus4;
    logic [31:0]     w_pred_target;
    logic            w_pred_taken;

    set_idx_t        w_upd_set;
    tag_t            w_upd_tag;
    btb_entry_t      w_pb_entry [2];
    logic            w_uhit0;
    logic            w_uhit1;
    logic [1:0]      w_way_we;
    logic            w_victim;
    btb_entry_t      w_wr_entry;
    logic            w_unused;

    // ------------------------------------------------------------------
    // Storage: two identical ways, sharing index and write data
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_way
        btb_way_array u_way (
            .clk        (clk),
            .rstn       (rstn),
            .i_lk_set   (w_lk_set),
            .o_lk_entry (w_lk_entry[g]),
            .i_pb_set   (w_upd_set),
            .o_pb_entry (w_pb_entry[g]),
            .i_we       (w_way_we[g]),
            .i_wr_set   (w_upd_set),
            .i_wr_entry (w_wr_entry)
        );
    end

    // ------------------------------------------------------------------
    // Fetch lookup
    // ------------------------------------------------------------------
    assign w_lk_set   = pc_set(r_pc);
    assign w_lk_tag   = pc_tag(r_pc);
    assign w_pc_plus4 = r_pc + 32'd4;   // wraps modulo 2^32

    assign w_hit0    = w_lk_entry[0].valid && (w_lk_entry[0].tag == w_lk_tag);
    assign w_hit1    = w_lk_entry[1].valid && (w_lk_entry[1].tag == w_lk_tag);
    assign w_btb_hit = w_hit0 | w_hit1;

    // Select the hitting way's target and jump flag; way 0 wins a double hit.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_pred_target = w_pc_plus4;
        w_hit_jump    = 1'b0;
        if (w_hit0) begin
            w_pred_target = w_lk_entry[0].target;
            w_hit_jump    = w_lk_entry[0].is_jump;
        end else if (w_hit1) begin
            w_pred_target = w_lk_entry[1].target;
            w_hit_jump    = w_lk_entry[1].is_jump;
        end
    end

    assign w_pred_taken = w_btb_hit & (bus.bp_predict | w_hit_jump);

    // ------------------------------------------------------------------
    // Training: tag probe, way choice, write
    // ------------------------------------------------------------------
    assign w_upd_set = pc_set(bus.upd_pc);
    assign w_upd_tag = pc_tag(bus.upd_pc);

    assign w_uhit0 = w_pb_entry[0].valid && (w_pb_entry[0].tag == w_upd_tag);
    assign w_uhit1 = w_pb_entry[1].valid && (w_pb_entry[1].tag == w_upd_tag);

    // Refresh a hitting way; on a taken miss fill the lowest invalid way, else the LRU victim.
    always_comb begin
        w_way_we = 2'b00;
        w_victim = 1'b0;
        if (bus.upd_we) begin
            if (w_uhit0) begin
                w_way_we = 2'b01;
                w_victim = 1'b0;
            end else if (w_uhit1) begin
                w_way_we = 2'b10;
                w_victim = 1'b1;
            end else if (bus.upd_taken) begin
                if (!w_pb_entry[0].valid) begin
                    w_victim = 1'b0;
                end else if (!w_pb_entry[1].valid) begin
                    w_victim = 1'b1;
                end else begin
                    w_victim = r_lru[w_upd_set];
                end
                w_way_we = w_victim ? 2'b10 : 2'b01;
            end
        end
    end

    assign w_wr_entry.valid   = 1'b1;
    assign w_wr_entry.tag     = w_upd_tag;
    assign w_wr_entry.target  = bus.upd_target;
    assign w_wr_entry.is_jump = bus.upd_is_jump;

    // LRU points at the way not just written; lookups never touch it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lru <= '0;
        end else if (|w_way_we) begin
            r_lru[w_upd_set] <= ~w_victim;
        end
    end

    // ------------------------------------------------------------------
    // PC register: redirect beats stall, stall beats prediction
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= RESET_PC;
        end else if (bus.redirect) begin
            r_pc <= bus.redirect_pc;
        end else if (!bus.stall) begin
            r_pc <= w_pred_taken ? w_pred_target : w_pc_plus4;
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pred_taken  = w_pred_taken;
    assign bus.pred_target = w_pred_target;
    assign bus.btb_hit     = w_btb_hit;

    // Byte-offset bits of the training PC carry no BTB information.
    assign w_unused = &{1'b0, bus.upd_pc[1:0]};

endmodule

// File: doc/btb_fetch_pc.md
Name: btb_fetch_pc

Overview:
- Fetch-stage next-PC unit. Owns the IF program counter and a 2-way set-associative branch target buffer (BTB).
- Each cycle it combines its BTB hit/target with the direction bit from the downstream-adjacent branch_predict block (record_chk_pc = pc[6:2]) to pick the next PC.
- EX-stage branch resolution trains the BTB and redirects fetch on mispredict.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- SET_BITS, 5, index width; SETS = 2**SET_BITS = 32, index = pc[SET_BITS+1:2].
- TAG_BITS, 25, tag = pc[31:SET_BITS+2]; must equal 30-SET_BITS.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- stall  in  1  hold PC (hazard unit).
- redirect  in  1  EX mispredict; load redirect_pc.
- redirect_pc  in  32  correct PC from EX.
- bp_predict  in  1  direction prediction from branch_predict for the current pc.
- upd_we  in  1  EX resolved a branch/jump this cycle.
- upd_pc  in  32  PC of resolved instruction.
- upd_target  in  32  resolved target address.
- upd_taken  in  1  resolved direction.
- upd_is_jump  in  1  unconditional (jal/jalr); overrides bp_predict on hit.
- pc  out  32  current fetch PC (register).
- pred_taken  out  1  fetch predicted taken; piped to EX for mispredict check.
- pred_target  out  32  predicted target (valid when pred_taken).
- btb_hit  out  1  lookup hit.

Behaviour:
- Reset (async, rstn=0): pc=RESET_PC; all valid bits and LRU bits=0.
  - Target/tag arrays are not reset.
  - pred_taken=0 and btb_hit=0 follow from the cleared valid bits.
- Lookup is combinational on pc, zero latency.
  - set = pc[6:2]; hit_w = valid[set][w] & tag[set][w]==pc[31:7].
  - Both ways hitting cannot occur; if it does, way 0 wins.
  - btb_hit = hit0|hit1.
  - pred_target = hit way's target, else pc+4.
  - pred_taken = btb_hit & (bp_predict | is_jump of hit way).
- PC register update at posedge, priority:
  - redirect: pc<=redirect_pc. This holds regardless of stall.
  - else stall: pc holds.
  - else pc<=pred_taken ? pred_target : pc+4.
  - pc+4 wraps modulo 2^32.
- BTB update at posedge when upd_we=1, indexed by upd_pc:
  - Tag hit in way w: rewrite target and is_jump; lru[set] <= ~w, pointing at the victim.
  - Miss and upd_taken=1: allocate. Use the lowest invalid way if any, else way lru[set]. Write valid=1, tag, target, is_jump; lru[set] <= ~allocated way.
  - Miss and upd_taken=0: no change.
  - Not-taken on a hit still refreshes target/is_jump; the entry is never invalidated.
- Lookups do not touch LRU.
- Simultaneous upd_we and lookup of the same set: lookup sees pre-update contents (read-old). The new entry is visible the following cycle.
- upd_we and redirect are independent. Both occur in the same cycle on a mispredict and both take effect.
- Reset asserted mid-operation: immediate clear as above; in-flight update is lost.
- pc[1:0] are passed through, not checked. Misaligned PCs are the ISA logic's concern.

Decomposition:
- Shared package: RESET_PC default, SET_BITS, TAG_BITS, and a BTB entry struct {valid, tag, target, is_jump}.
- One natural sub-module: btb_way_array. It is a single way's storage with a combinational read port and a synchronous write port, instantiated twice.
- LRU, allocation and PC logic stay in the top.

Test Plan:
- Reset: hold rstn=0 two cycles, release; stall=0 → pc=0,4,8,12 on successive cycles; btb_hit=0.
- Allocate then hit:
  - Stimulus: upd_we with upd_pc=0x10, upd_target=0x40, upd_taken=1, upd_is_jump=0. Next cycle pc=0x10 with bp_predict=1.
  - Required: btb_hit=1, pred_taken=1, next pc=0x40.
  - Same lookup with bp_predict=0: pred_taken=0, next pc=0x14.
- Jump override: allocate pc=0x20→0x100 with is_jump=1; at pc=0x20 with bp_predict=0 → pred_taken=1, next pc=0x100.
- Set conflict / LRU:
  - Allocate 0x0010→0xA0, then 0x1010→0xB0 (same set 4, both ways valid), then 0x2010→0xC0.
  - Required: 0x0010 is evicted (way 0); lookups of 0x1010 and 0x2010 hit; 0x0010 misses.
- Priority:
  - stall=1 and redirect=1 with redirect_pc=0x200 in the same cycle → pc=0x200 next cycle.
  - stall=1 alone → pc unchanged for 3 cycles.
- Same-cycle update/lookup: pc=0x30 while upd_we allocates 0x30→0x80 → that cycle btb_hit=0, next pc=0x34.
